// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked 6502-style ALU.
//
// Binary operations are computed and registered on the accept edge, so the
// result is valid one cycle later. When ALU_SEQ_DECIMAL_EN is defined,
// ADC/SBC with decimal=1 run a digit-serial BCD adjust, one nibble per
// cycle (DIGITS cycles). Result, flags and mask are held until the
// consumer takes them.
//
// Configuration macro: ALU_SEQ_DECIMAL_EN (undefined: decimal input ignored,
// no DADJ state, every op has latency 1).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds its payload stable while valid && !ready.
// flush wins over a simultaneous request and drops any operation in flight.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   request handshake
//   op, a, mem, src_sel,  operation, operands, shift/INC/DEC source select,
//   carry_in, decimal     P.C and P.D
//   flush                 synchronous abort to IDLE
//   out_valid / out_ready result handshake
//   result, flag_c/z/v/n  registered result and flags (masked-off flags = 0)
//   flag_mask             {C,Z,V,N} update enables for the op
//   The FSM state is visible as the internal signal 'state'.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] mem,
    input  logic         src_sel,
    input  logic         carry_in,
    input  logic         decimal,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_c,
    output logic         flag_z,
    output logic         flag_v,
    output logic         flag_n,
    output logic [3:0]   flag_mask
);

    localparam int DIGITS = N / 4;

    if (N % 4 != 0) begin : g_bad_width
        $error("alu_seq: N must be a multiple of 4");
    end

    localparam logic [3:0] OP_ADC = 4'd0, OP_SBC = 4'd1, OP_AND = 4'd2,
                           OP_ORA = 4'd3, OP_EOR = 4'd4, OP_ASL = 4'd5,
                           OP_LSR = 4'd6, OP_ROL = 4'd7, OP_ROR = 4'd8,
                           OP_CMP = 4'd9, OP_INC = 4'd10, OP_DEC = 4'd11;

`ifdef ALU_SEQ_DECIMAL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DADJ = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t state, state_next;

    logic         accept;
    logic         load_bin;
    logic [N-1:0] src;
    logic [N-1:0] addend;
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N-1:0] bin_res;
    logic         bin_c, bin_v;
    logic [3:0]   bin_mask;
    logic [3:0]   bin_flags;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
    logic [3:0]   mask_q;

    // ------------------------------------------------------------------
    // Binary datapath
    // ------------------------------------------------------------------
    always_comb begin
        src      = src_sel ? mem : a;
        addend   = (op == OP_SBC) ? ~mem : mem;
        sum      = {1'b0, a} + {1'b0, addend} + {{N{1'b0}}, carry_in};
        diff     = {1'b0, a} + {1'b0, ~mem} + {{N{1'b0}}, 1'b1};
        bin_res  = a;
        bin_c    = 1'b0;
        bin_v    = (a[N-1] ^ sum[N-1]) & (addend[N-1] ^ sum[N-1]);
        bin_mask = 4'b0000;
        case (op)
            OP_ADC, OP_SBC: begin bin_res = sum[N-1:0]; bin_c = sum[N]; bin_mask = 4'b1111; end
            OP_AND: begin bin_res = a & mem; bin_mask = 4'b0101; end
            OP_ORA: begin bin_res = a | mem; bin_mask = 4'b0101; end
            OP_EOR: begin bin_res = a ^ mem; bin_mask = 4'b0101; end
            OP_ASL: begin bin_res = {src[N-2:0], 1'b0};     bin_c = src[N-1]; bin_mask = 4'b1101; end
            OP_LSR: begin bin_res = {1'b0, src[N-1:1]};     bin_c = src[0];   bin_mask = 4'b1101; end
            OP_ROL: begin bin_res = {src[N-2:0], carry_in}; bin_c = src[N-1]; bin_mask = 4'b1101; end
            OP_ROR: begin bin_res = {carry_in, src[N-1:1]}; bin_c = src[0];   bin_mask = 4'b1101; end
            OP_CMP: begin bin_res = diff[N-1:0]; bin_c = diff[N]; bin_mask = 4'b1101; end
            OP_INC: begin bin_res = src + N'(1); bin_mask = 4'b0101; end
            OP_DEC: begin bin_res = src - N'(1); bin_mask = 4'b0101; end
            default: begin bin_res = a; bin_mask = 4'b0000; end
        endcase
        bin_flags = {bin_c, (bin_res == '0), bin_v, bin_res[N-1]} & bin_mask;
    end

`ifdef ALU_SEQ_DECIMAL_EN
    // ------------------------------------------------------------------
    // Digit-serial BCD engine. Operands shift right one nibble per step;
    // adjusted nibbles shift into the top of result_q, so after DIGITS
    // steps the result is in place without any indexed writes.
    // ------------------------------------------------------------------
    localparam int DW = $clog2(DIGITS + 1);
    localparam logic [DW-1:0] LAST = DW'(DIGITS - 1);

    logic          dec_op, load_dec, dec_step;
    logic [N-1:0]  a_q, m_q;
    logic          carry_q, v_q, sub_q;
    logic [DW-1:0] digit;
    logic [5:0]    s_pre, s_adj;
    logic [4:0]    t;
    logic [3:0]    nib;
    logic          dc_next;
    logic [N+3:0]  shifted;
    logic [N-1:0]  dec_res;

    assign dec_op = decimal && (op == OP_ADC || op == OP_SBC);

    always_comb begin
        s_pre   = {2'b00, a_q[3:0]} + {2'b00, m_q[3:0]} + {5'b0, carry_q};
        s_adj   = (s_pre > 6'd9) ? s_pre + 6'd6 : s_pre;
        t       = {1'b0, a_q[3:0]} - {1'b0, m_q[3:0]} - {4'b0, ~carry_q};
        if (sub_q) begin
            // A negative 5-bit difference means a borrow; subtracting 6
            // folds the low nibble back into the 0..9 range.
            nib     = t[4] ? (t[3:0] - 4'd6) : t[3:0];
            dc_next = ~t[4];
        end else begin
            nib     = s_adj[3:0];
            dc_next = (s_adj > 6'd15) || (s_pre > 6'd9);
        end
        shifted = {nib, result_q};
        dec_res = shifted[N+3:4];
    end
`else
    logic unused_decimal;
    assign unused_decimal = decimal;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_bin   = 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
        load_dec   = 1'b0;
        dec_step   = 1'b0;
`endif
        if (flush) begin
            state_next = IDLE;
        end else if (accept) begin
`ifdef ALU_SEQ_DECIMAL_EN
            if (dec_op) begin
                load_dec   = 1'b1;
                state_next = DADJ;
            end else begin
                load_bin   = 1'b1;
                state_next = DONE;
            end
`else
            load_bin   = 1'b1;
            state_next = DONE;
`endif
        end else begin
            case (state)
                DONE: if (out_ready) state_next = IDLE;
`ifdef ALU_SEQ_DECIMAL_EN
                DADJ: begin
                    dec_step = 1'b1;
                    if (digit == LAST) state_next = DONE;
                end
`endif
                default: state_next = state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result / flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
            mask_q   <= '0;
`ifdef ALU_SEQ_DECIMAL_EN
            a_q      <= '0;
            m_q      <= '0;
            carry_q  <= 1'b0;
            v_q      <= 1'b0;
            sub_q    <= 1'b0;
            digit    <= '0;
`endif
        end else begin
            if (load_bin) begin
                result_q <= bin_res;
                flags_q  <= bin_flags;
                mask_q   <= bin_mask;
            end
`ifdef ALU_SEQ_DECIMAL_EN
            if (load_dec) begin
                a_q     <= a;
                m_q     <= mem;
                carry_q <= carry_in;
                v_q     <= bin_v;
                sub_q   <= (op == OP_SBC);
                digit   <= '0;
            end
            if (dec_step) begin
                a_q      <= a_q >> 4;
                m_q      <= m_q >> 4;
                carry_q  <= dc_next;
                result_q <= dec_res;
                digit    <= digit + DW'(1);
                if (digit == LAST) begin
                    // Z/N from the adjusted value, V from the binary sum.
                    flags_q <= {dc_next, (dec_res == '0), v_q, dec_res[N-1]};
                    mask_q  <= 4'b1111;
                end
            end
`endif
        end
    end

    assign result    = result_q;
    assign {flag_c, flag_z, flag_v, flag_n} = flags_q;
    assign flag_mask = mask_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the combinational 6502 ALU. Binary ops complete in one cycle. With decimal mode, ADC/SBC run a digit-serial BCD engine, one nibble per cycle. Sits between the decode/sequencer and the accumulator/P-register writeback. Result and flags are held until the consumer takes them.

Parameters:
N, 8, datapath width; must be a multiple of 4 (elaboration error otherwise)
DIGITS, N/4, derived localparam; BCD digit count and decimal-op cycle count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  request accepted when in_valid && in_ready at clk edge
op  in  4  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 CMP, 10 INC, 11 DEC, 12-15 PASS (result=a)
a  in  N  accumulator operand
mem  in  N  memory operand
src_sel  in  1  shift/INC/DEC source: 0=a, 1=mem
carry_in  in  1  P.C
decimal  in  1  P.D; affects ADC/SBC only
flush  in  1  synchronous abort: any state -> IDLE, out_valid=0
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts when out_valid && out_ready
result  out  N  registered result
flag_c, flag_z, flag_v, flag_n  out  1 each  registered flags
flag_mask  out  4  {C,Z,V,N} update enables for this op

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, flag_mask=0, digit counter 0.
- States: IDLE, DADJ, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 in DADJ.
- Accept, binary path (any op except ADC/SBC with decimal=1): compute and register everything on the accept edge, then go to DONE. out_valid is 1 the cycle after accept (latency 1).
- Accept, decimal ADC/SBC: register operands, carry_in, and V from the binary computation. digit=0, go to DADJ.
- DADJ: each edge processes nibble[digit].
  - ADC: s = a_d + m_d + c; if s > 9 then s = s + 6. Carry out = (s > 15 after adjust) or (s_pre > 9). Store s[3:0].
  - SBC: s = a_d - m_d - !c (5-bit); if s[4] then s = s - 6 and borrow out. Carry out = !borrow.
  - After digit DIGITS-1, go to DONE. Latency is DIGITS cycles (2 for N=8).
  - Non-BCD digits are processed by the same formula; no error flag.
- DONE: hold result, flags and mask stable while out_ready=0.
  - On out_ready: accept a new request if in_valid (back-to-back, no bubble); otherwise go to IDLE.
- Arithmetic (binary), all mod 2^N:
  - ADC: a + mem + c.
  - SBC: a + ~mem + c.
  - V = (a^r)&(m'^r) at the MSB, where m' is the adder's second operand.
  - C = carry out of bit N-1.
- CMP: r = a - mem. C = (a >= mem unsigned). Mask {C,Z,N}.
- Shifts on src: ASL/LSR fill with 0; ROL/ROR fill with carry_in. C = the bit shifted out.
- INC/DEC: src ±1, wrapping (0xFF+1=0x00, 0x00-1=0xFF). Mask {Z,N}.
- AND/ORA/EOR: mask {Z,N}. PASS: mask 0.
- Z = (r==0). N = r[N-1]. Decimal ops derive Z/N from the adjusted result; V comes from the binary sum.
- Masked-off flags are output as 0.
- Reset or flush mid-DADJ: operation discarded, no out_valid.
- flush has priority over a simultaneous accept.

Optional Feature:
Macro ALU_SEQ_DECIMAL_EN.
- Defined: decimal ADC/SBC use DADJ as specified above.
- Undefined: the decimal input is ignored, the DADJ state and digit counter are not built, and every op has latency 1.

Test Plan:
- ADC a=0x50 mem=0x50 c=0 d=0 -> 1 cycle later: result=0xA0, N=1 V=1 C=0 Z=0, mask=4'b1111.
- ADC BCD a=0x58 mem=0x46 c=1 d=1 -> in_ready=0 for 2 cycles; then result=0x05, C=1, Z=0.
- SBC BCD a=0x12 mem=0x21 c=1 d=1 -> result=0x91, C=0; SBC binary a=0x00 mem=0x01 c=1 -> result=0xFF, C=0 N=1.
- CMP a=0x40 mem=0x40 -> result=0x00, Z=1 C=1, mask={C,Z,N}. ROR src=mem mem=0x01 c=1 -> result=0x80, C=1 N=1.
- Backpressure: out_ready=0 for 5 cycles after ASL a=0x81 -> result=0x02/C=1 held stable with in_ready=0; then out_ready=1 with in_valid=1 (INC a) -> new request accepted the same edge.
- rst_n low during cycle 1 of DADJ -> all outputs 0 asynchronously; after release out_valid=0 and in_ready=1. A flush pulse mid-DADJ likewise yields no result.
